cpu_ctrl_fsm: RTL
=================

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous, active-low (0 = reset).
REQ-002 SHALL have port: instWord  input  32  instruction word from instruction memory; op1 = instWord[3:0], op2 = instWord[7:4].
REQ-003 SHALL have port: aluCond  input  1  ALU compare result, valid in EXEC.
REQ-004 SHALL have port: memReady  input  1  data memory/IO access complete.
REQ-005 SHALL have outputs, all 1 bit unless stated: irWrtEn (latch instruction); pcWrtEn (update PC); pcSel 2 (0 = PC+4, 1 = branch target, 2 = JAL target); regSel (RS field select); argSel (0 = DATA2, 1 = immediate); WR_EN (register-file write); regInSel 2 (0 = ALU, 1 = memory, 2 = PC+4); memRdEn; memWrEn; aluFunc 4; trap.

Function
REQ-006 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP; all outputs SHALL be decoded from state plus the latched op1/op2 (Moore style).
REQ-007 SHALL leave IDLE for FETCH unconditionally one cycle after reset deasserts.
REQ-008 FETCH SHALL assert irWrtEn for exactly 1 cycle, then go to DECODE.
REQ-009 DECODE SHALL latch op1/op2 and go to EXEC.
REQ-010 EXEC SHALL route by op1:
- ALUR, ALUI, CMPR, CMPI, JAL -> WB.
- LW, SW -> MEM.
- BCOND -> FETCH.
REQ-011 BCOND in EXEC SHALL assert pcWrtEn for 1 cycle with pcSel = 1 if aluCond = 1, else pcSel = 0.
REQ-012 MEM SHALL hold memRdEn (LW) or memWrEn (SW) high until a cycle with memReady = 1, then:
- LW -> WB.
- SW -> FETCH, asserting pcWrtEn with pcSel = 0 in that cycle.
REQ-013 memReady SHALL be ignored outside MEM; a wait of unbounded length SHALL be tolerated.
REQ-014 WB SHALL assert WR_EN and pcWrtEn for exactly 1 cycle, then go to FETCH:
- regInSel = 1 for LW, 2 for JAL, else 0.
- pcSel = 2 for JAL, else 0.
REQ-015 pcWrtEn SHALL pulse exactly once per retired instruction; WR_EN SHALL never pulse for SW or BCOND.
REQ-016 argSel SHALL be 1 for ALUI, CMPI, LW, SW and JAL, and 0 otherwise.
REQ-017 regSel SHALL be 1 for SW and BCOND, and 0 otherwise.
REQ-018 aluFunc SHALL be:
- op2 for ALUR, ALUI, CMPR, CMPI and BCOND.
- 4'b0000 (add) for LW, SW and JAL.
REQ-019 Latency in cycles, FETCH through PC update:
- ALU/CMP and JAL: 4.
- BCOND: 3.
- SW: 4 + memory wait.
- LW: 5 + memory wait.

Reset
REQ-020 Reset assertion SHALL immediately force state IDLE and drive all outputs to 0, including mid-MEM access; memRdEn/memWrEn SHALL drop without waiting for clk.
REQ-021 In IDLE all outputs SHALL be 0.

Configuration
REQ-022 With macro ILLEGAL_OP_TRAP_EN defined, an op1 outside the eight defined opcodes in EXEC SHALL go to TRAP; TRAP holds trap = 1 and all other outputs 0 until reset.
REQ-023 Without ILLEGAL_OP_TRAP_EN, an undefined op1 SHALL execute as a NOP: EXEC -> FETCH with pcWrtEn = 1 and pcSel = 0; trap SHALL be tied 0.

Verification
REQ-024 ALUR with op1 = 0000, op2 = 0011 -> irWrtEn in cycle 1; WR_EN = 1, pcWrtEn = 1, regInSel = 0, aluFunc = 0011 in cycle 4; no memory strobes.
REQ-025 BCOND with aluCond = 1 -> pcWrtEn = 1, pcSel = 1 in cycle 3; with aluCond = 0 -> pcSel = 0; WR_EN stays 0 in both cases.
REQ-026 LW with memReady held low for 3 MEM cycles -> memRdEn high 4 cycles; WB has WR_EN = 1, regInSel = 1; pcWrtEn pulses once at cycle 8.
REQ-027 JAL -> argSel = 1, aluFunc = 0000; WB has WR_EN = 1, regInSel = 2, pcSel = 2.
REQ-028 Reset asserted during the SW MEM wait -> memWrEn falls before the next clk edge; after release: IDLE, then FETCH, with no spurious pcWrtEn.
REQ-029 op1 = 1111 -> with ILLEGAL_OP_TRAP_EN: trap = 1 persists for 20 cycles and pcWrtEn stays 0; without it: pcWrtEn = 1, pcSel = 0 in cycle 3, then FETCH.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Optional feature macro ILLEGAL_OP_TRAP_EN: undefined opcodes enter a sticky TRAP state instead of executing as a NOP.
module cpu_ctrl_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instWord,
    input  logic        aluCond,
    input  logic        memReady,
    output logic        irWrtEn,
    output logic        pcWrtEn,
    output logic [1:0]  pcSel,
    output logic        regSel,
    output logic        argSel,
    output logic        WR_EN,
    output logic [1:0]  regInSel,
    output logic        memRdEn,
    output logic        memWrEn,
    output logic [3:0]  aluFunc,
    output logic        trap
);

    localparam logic [3:0] OP_ALUR  = 4'd0;
    localparam logic [3:0] OP_ALUI  = 4'd1;
    localparam logic [3:0] OP_CMPR  = 4'd2;
    localparam logic [3:0] OP_CMPI  = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_BCOND = 4'd6;
    localparam logic [3:0] OP_JAL   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op1_q, op1_d;
    logic [3:0] op2_q, op2_d;

    logic is_alu, is_lw, is_sw, is_bcond, is_jal, op_defined, op_active;
    logic unused_inst;

    // Only the two opcode nibbles are consumed; the rest belongs to the datapath.
    assign unused_inst = ^instWord[31:8];

    assign is_alu     = (op1_q == OP_ALUR) || (op1_q == OP_ALUI) ||
                        (op1_q == OP_CMPR) || (op1_q == OP_CMPI);
    assign is_lw      = (op1_q == OP_LW);
    assign is_sw      = (op1_q == OP_SW);
    assign is_bcond   = (op1_q == OP_BCOND);
    assign is_jal     = (op1_q == OP_JAL);
    assign op_defined = is_alu || is_lw || is_sw || is_bcond || is_jal;
    assign op_active  = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op1_d   = instWord[3:0];
                op2_d   = instWord[7:4];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!op_defined) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_bcond) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            // Wait here as long as memory needs; memReady matters nowhere else.
            S_MEM: begin
                if (memReady) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op1_q   <= 4'd0;
            op2_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    // Outputs decode from the state register, so reset clears them without a clock edge.
    always_comb begin
        irWrtEn  = 1'b0;
        pcWrtEn  = 1'b0;
        pcSel    = 2'd0;
        regSel   = 1'b0;
        argSel   = 1'b0;
        WR_EN    = 1'b0;
        regInSel = 2'd0;
        memRdEn  = 1'b0;
        memWrEn  = 1'b0;
        aluFunc  = 4'b0000;
        if (op_active) begin
            argSel  = (op1_q == OP_ALUI) || (op1_q == OP_CMPI) || is_lw || is_sw || is_jal;
            regSel  = is_sw || is_bcond;
            aluFunc = (is_alu || is_bcond) ? op2_q : 4'b0000;
        end
        case (state_q)
            S_FETCH: irWrtEn = 1'b1;
            S_EXEC: begin
                if (is_bcond) begin
                    pcWrtEn = 1'b1;
                    pcSel   = aluCond ? 2'd1 : 2'd0;
                end
`ifndef ILLEGAL_OP_TRAP_EN
                else if (!op_defined) begin
                    pcWrtEn = 1'b1;
                end
`endif
            end
            S_MEM: begin
                memRdEn = is_lw;
                memWrEn = is_sw;
                pcWrtEn = is_sw && memReady;
            end
            S_WB: begin
                WR_EN    = 1'b1;
                pcWrtEn  = 1'b1;
                pcSel    = is_jal ? 2'd2 : 2'd0;
                regInSel = is_lw ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign trap = (state_q == S_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule
